zap_wb_arbiter: RTL
===================

Name: zap_wb_arbiter

Overview:
- Two-master to one-slave Wishbone arbiter that sits directly upstream of the store-FIFO Wishbone adapter.
- Merges the code-cache master (read-only) and the data-cache master (read/write) into the single processor Wishbone interface the adapter consumes (CYC/STB/SEL/CTI/ADR/DAT/WE in, DAT/ACK back).
- Round-robin arbitration; grant is locked for the duration of a burst; the ACK is routed only to the granted master.

Parameters:
- FIRST_GRANT, 0, master served first after reset when both request (0 = code, 1 = data).

Ports:
- i_clk  input  1  clock.
- i_reset_n  input  1  asynchronous, active-low reset.
- i_c_wb_cyc  input  1  code master cycle.
- i_c_wb_stb  input  1  code master strobe.
- i_c_wb_sel  input  4  code master byte select.
- i_c_wb_cti  input  3  code master cycle type.
- i_c_wb_adr  input  32  code master address.
- o_c_wb_dat  output  32  read data to code master.
- o_c_wb_ack  output  1  ack to code master.
- i_d_wb_cyc  input  1  data master cycle.
- i_d_wb_stb  input  1  data master strobe.
- i_d_wb_sel  input  4  data master byte select.
- i_d_wb_cti  input  3  data master cycle type.
- i_d_wb_adr  input  32  data master address.
- i_d_wb_dat  input  32  data master write data.
- i_d_wb_we  input  1  data master write enable.
- o_d_wb_dat  output  32  read data to data master.
- o_d_wb_ack  output  1  ack to data master.
- o_wb_cyc, o_wb_stb  output  1 each  to adapter.
- o_wb_sel  output  4  to adapter.
- o_wb_cti  output  3  to adapter.
- o_wb_adr, o_wb_dat  output  32 each  to adapter.
- o_wb_we  output  1  to adapter.
- i_wb_dat  input  32  read data from adapter.
- i_wb_ack  input  1  ack from adapter.

Behaviour:
- State register: IDLE, GNT_C, GNT_D. Round-robin pointer last_ff records the last master granted.
- Reset: i_reset_n low forces, asynchronously, state=IDLE and last_ff = ~FIRST_GRANT. This holds even mid-burst; no pending beat is completed and no ACK is generated.
- Output mux is combinational from the registered state:
  - IDLE: all o_wb_* = 0.
  - GNT_C: o_wb_* = code inputs, with o_wb_dat=0 and o_wb_we=0.
  - GNT_D: o_wb_* = data inputs.
- ACK routing: o_c_wb_ack = i_wb_ack & (state==GNT_C); o_d_wb_ack = i_wb_ack & (state==GNT_D). Never both high.
- Read data: o_c_wb_dat = o_d_wb_dat = i_wb_dat (broadcast; qualified by the routed ACK).
- Grant latency: 1 cycle. A request (cyc high) seen in IDLE is granted at the next edge. Arbitration is never combinational within the same cycle.
- IDLE transitions:
  - Only code cyc high -> GNT_C.
  - Only data cyc high -> GNT_D.
  - Both high -> the master != last_ff.
  - Neither -> stay IDLE.
  - last_ff is updated on every grant.
- Terminating beat: a cycle where i_wb_ack=1 and the granted master's cti is 3'b000 (classic) or 3'b111 (end-of-burst).
- GNT_x transitions:
  - Master x drops cyc: go to GNT_other if the other master's cyc is high, else IDLE.
  - Terminating beat and the other master's cyc is high: go to GNT_other (fairness handoff), even if x keeps cyc high.
  - Beat acked with cti=3'b010 (incrementing burst): stay; grant is locked until the terminating beat.
  - Otherwise stay.
- Handoff never creates a gap beat toward the adapter beyond the state change. The new master's signals appear on o_wb_* the cycle after the edge.
- Simultaneous events: ACK and the other master's first cyc in the same cycle with a terminating beat -> handoff at that edge. ACK while x's cyc is low -> ACK is still routed to x (no suppression).

Test Plan:
- Reset mid-burst: data burst in progress, pull i_reset_n low for 1 cycle -> o_wb_cyc=0 immediately; state IDLE; no ACK to either master.
- Single code read: i_c_wb_cyc/stb=1, cti=000, adr=0x100 -> o_wb_adr=0x100, o_wb_we=0 one cycle later. Adapter ack with i_wb_dat=0xDEADBEEF -> o_c_wb_ack=1, o_c_wb_dat=0xDEADBEEF, o_d_wb_ack=0.
- Simultaneous first requests, FIRST_GRANT=0: both cyc rise together -> code granted first. After its classic beat is acked, data is granted at the next edge.
- Burst lock: data 4-beat burst (cti 010,010,010,111, adr 0x200..0x20C) with code requesting throughout -> all 4 beats stay on data; code is granted the cycle after the 111 ACK.
- Data write: i_d_wb_we=1, dat=0x12345678, sel=4'hF -> passed unmodified to o_wb_*. Code port writes are impossible (o_wb_we=0 in GNT_C).
- Round-robin: both masters issue back-to-back classic requests for 6 transactions -> grants alternate C,D,C,D,C,D. The ACK count per master is 3.

Source files
------------

// File: rtl/zap_wb_arbiter.sv
// ============================================================================
// Module   : zap_wb_arbiter
// Purpose  : Two-master (code cache, data cache) to one-slave Wishbone
//            arbiter feeding the store-FIFO Wishbone adapter. Round-robin
//            between masters, grant locked across incrementing bursts,
//            ACK routed only to the granted master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module zap_wb_arbiter #(
  parameter logic FIRST_GRANT = 1'b0  // 0 = code, 1 = data
) (
  input  logic        i_clk,
  input  logic        i_reset_n,

  // Code-cache master (read-only)
  input  logic        i_c_wb_cyc,
  input  logic        i_c_wb_stb,
  input  logic [3:0]  i_c_wb_sel,
  input  logic [2:0]  i_c_wb_cti,
  input  logic [31:0] i_c_wb_adr,
  output logic [31:0] o_c_wb_dat,
  output logic        o_c_wb_ack,

  // Data-cache master (read/write)
  input  logic        i_d_wb_cyc,
  input  logic        i_d_wb_stb,
  input  logic [3:0]  i_d_wb_sel,
  input  logic [2:0]  i_d_wb_cti,
  input  logic [31:0] i_d_wb_adr,
  input  logic [31:0] i_d_wb_dat,
  input  logic        i_d_wb_we,
  output logic [31:0] o_d_wb_dat,
  output logic        o_d_wb_ack,

  // Towards the adapter
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic [3:0]  o_wb_sel,
  output logic [2:0]  o_wb_cti,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic        o_wb_we,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_ack
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_C = 2'd1,
    GNT_D = 2'd2
  } state_t;

  localparam logic MASTER_C = 1'b0;
  localparam logic MASTER_D = 1'b1;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  state_t state_q, state_d;
  logic   last_q,  last_d;   // last master granted

  // A beat ends the granted master's transfer when it is acked as classic or end-of-burst.
  logic term_c, term_d;
  assign term_c = i_wb_ack && ((i_c_wb_cti == CTI_CLASSIC) || (i_c_wb_cti == CTI_EOB));
  assign term_d = i_wb_ack && ((i_d_wb_cti == CTI_CLASSIC) || (i_d_wb_cti == CTI_EOB));

  // Next-state arbitration; grant takes effect at the following edge only.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (i_c_wb_cyc && i_d_wb_cyc) begin
          // Contention: serve whoever was not served last.
          if (last_q == MASTER_C) begin
            state_d = GNT_D;
            last_d  = MASTER_D;
          end else begin
            state_d = GNT_C;
            last_d  = MASTER_C;
          end
        end else if (i_c_wb_cyc) begin
          state_d = GNT_C;
          last_d  = MASTER_C;
        end else if (i_d_wb_cyc) begin
          state_d = GNT_D;
          last_d  = MASTER_D;
        end
      end
      GNT_C: begin
        // Hand off on cycle drop, or on a terminating beat when data waits.
        if (!i_c_wb_cyc || (term_c && i_d_wb_cyc)) begin
          if (i_d_wb_cyc) begin
            state_d = GNT_D;
            last_d  = MASTER_D;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GNT_D: begin
        if (!i_d_wb_cyc || (term_d && i_c_wb_cyc)) begin
          if (i_c_wb_cyc) begin
            state_d = GNT_C;
            last_d  = MASTER_C;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and round-robin pointer; asynchronous reset abandons any open beat.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      last_q  <= ~FIRST_GRANT;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Output mux driven only by the registered grant; the code port can never write.
  always_comb begin
    o_wb_cyc = 1'b0;
    o_wb_stb = 1'b0;
    o_wb_sel = 4'h0;
    o_wb_cti = 3'b000;
    o_wb_adr = 32'h0;
    o_wb_dat = 32'h0;
    o_wb_we  = 1'b0;
    case (state_q)
      GNT_C: begin
        o_wb_cyc = i_c_wb_cyc;
        o_wb_stb = i_c_wb_stb;
        o_wb_sel = i_c_wb_sel;
        o_wb_cti = i_c_wb_cti;
        o_wb_adr = i_c_wb_adr;
      end
      GNT_D: begin
        o_wb_cyc = i_d_wb_cyc;
        o_wb_stb = i_d_wb_stb;
        o_wb_sel = i_d_wb_sel;
        o_wb_cti = i_d_wb_cti;
        o_wb_adr = i_d_wb_adr;
        o_wb_dat = i_d_wb_dat;
        o_wb_we  = i_d_wb_we;
      end
      default: ;
    endcase
  end

  // Read data is broadcast; only the routed ACK qualifies it.
  assign o_c_wb_dat = i_wb_dat;
  assign o_d_wb_dat = i_wb_dat;
  assign o_c_wb_ack = i_wb_ack && (state_q == GNT_C);
  assign o_d_wb_ack = i_wb_ack && (state_q == GNT_D);

endmodule

`default_nettype wire
